// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: op codes,
// condition codes, NZCV flag bit positions and the stage FSM states.
package alu_pkg;

    // ALUControl encodings understood by the external ALU
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    // ARM-style condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Issue / execute / hold-result states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Codes above XOR have no ALU meaning
    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op > OP_XOR);
    endfunction

    // Arithmetic ops produce meaningful carry/overflow, logic ops do not
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM-style condition evaluator: decides whether an
// instruction with the given condition code executes under NZCV flags.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLG_N];
    assign z = flags[FLG_Z];
    assign c = flags[FLG_C];
    assign v = flags[FLG_V];

    // Decode the condition code against the current flags
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback stage around an external combinational ALU. Accepts one
// operation, drives the ALU for exactly one cycle, applies the condition
// code and flag-update rules, then holds the outcome until downstream takes it.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int         W         = 5,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_op,
    input  logic [3:0]   in_cond,
    input  logic         in_setflags,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_executed,
    output logic         out_illegal,
    output logic [3:0]   flags
);

    state_t       state_reg;
    state_t       state_next;

    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [2:0]   op_reg;
    logic [3:0]   cond_reg;
    logic         setflags_reg;

    logic [W-1:0] result_reg;
    logic [W-1:0] result_next;
    logic         executed_reg;
    logic         executed_next;
    logic         illegal_reg;
    logic         illegal_next;
    logic [3:0]   flags_reg;
    logic [3:0]   flags_next;

    logic         cond_pass;
    logic         op_illegal;
    logic         do_exec;

    // Condition is judged against the flags held at the start of EXEC
    cond_check u_cond_check (
        .cond  (cond_reg),
        .flags (flags_reg),
        .pass  (cond_pass)
    );

    assign op_illegal = op_is_illegal(op_reg);
    assign do_exec    = cond_pass & !op_illegal;

    // Operand registers load only on an accepted handshake in IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            cond_reg     <= '0;
            setflags_reg <= 1'b0;
        end else if ((state_reg == ST_IDLE) && in_valid) begin
            a_reg        <= in_a;
            b_reg        <= in_b;
            op_reg       <= in_op;
            cond_reg     <= in_cond;
            setflags_reg <= in_setflags;
        end
    end

    // State, result and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            result_reg   <= '0;
            executed_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            flags_reg    <= RST_FLAGS;
        end else begin
            state_reg    <= state_next;
            result_reg   <= result_next;
            executed_reg <= executed_next;
            illegal_reg  <= illegal_next;
            flags_reg    <= flags_next;
        end
    end

    // Next-state, result capture and flag-update rules
    always_comb begin
        state_next    = state_reg;
        result_next   = result_reg;
        executed_next = executed_reg;
        illegal_next  = illegal_reg;
        flags_next    = flags_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                illegal_next  = op_illegal;
                executed_next = do_exec;
                result_next   = do_exec ? alu_result : '0;
                if (do_exec && setflags_reg) begin
                    if (op_is_arith(op_reg)) begin
                        flags_next = alu_flags;
                    end else begin
                        // Logic ops only define N and Z; keep C and V
                        flags_next[FLG_N] = alu_flags[FLG_N];
                        flags_next[FLG_Z] = alu_flags[FLG_Z];
                    end
                end
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // in_ready is forced low for as long as reset is held
    assign in_ready     = (state_reg == ST_IDLE) && reset_n;
    assign out_valid    = (state_reg == ST_DONE);
    assign out_result   = result_reg;
    assign out_executed = executed_reg;
    assign out_illegal  = illegal_reg;
    assign flags        = flags_reg;

    // The ALU always sees the operand registers; only EXEC samples it
    assign alu_a    = a_reg;
    assign alu_b    = b_reg;
    assign alu_ctrl = op_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU and a
// transaction-level reference model checked every cycle.
module tb_alu_exec_ctrl;

    localparam int         W         = 5;
    localparam logic [3:0] RST_FLAGS = 4'b0000;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic [3:0]   in_cond;
    logic         in_setflags;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_executed;
    logic         out_illegal;
    logic [3:0]   flags;

    int tests = 0;
    int fails = 0;

    alu_exec_ctrl #(.W(W), .RST_FLAGS(RST_FLAGS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_cond      (in_cond),
        .in_setflags  (in_setflags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_executed (out_executed),
        .out_illegal  (out_illegal),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALU + reference model ----------------
    function automatic int sval(input logic [4:0] x);
        return x[4] ? int'(x) - 32 : int'(x);
    endfunction

    // Returns {N,Z,C,V, result[4:0]}
    function automatic logic [8:0] alu_fn(input logic [4:0] a, input logic [4:0] b,
                                          input logic [2:0] op);
        int r_int;
        int sr;
        logic [4:0] r;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        r = 5'd0;
        case (op)
            3'd0: begin
                r_int = int'(a) + int'(b);
                r = r_int[4:0];
                c = (r_int > 31);
                sr = sval(a) + sval(b);
                v = (sr > 15) || (sr < -16);
            end
            3'd1: begin
                r_int = int'(a) - int'(b);
                r = r_int[4:0];
                c = (a >= b);
                sr = sval(a) - sval(b);
                v = (sr > 15) || (sr < -16);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: return 9'd0;
        endcase
        return {r[4], (r == 5'd0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic [4:0] res;
        logic       exe;
        logic       ill;
        logic [3:0] fl;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] mflags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_valid: got out_valid=1 expected 0 at %0t", $time);
                end else begin
                    chk("cmp_result", 32'(out_result), 32'(expq[0].res));
                    chk("cmp_executed", 32'(out_executed), 32'(expq[0].exe));
                    chk("cmp_illegal", 32'(out_illegal), 32'(expq[0].ill));
                    chk("cmp_flags", 32'(flags), 32'(expq[0].fl));
                end
            end else if (in_ready) begin
                chk("cmp_idle_flags", 32'(flags), 32'(mflags));
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready && (expq.size() > 0)) begin
            void'(expq.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [2:0] op;
        logic [3:0] cond;
        logic       sf;
        int         hold;
        logic [4:0] eres;
        logic       eexe;
        logic       eill;
        logic [3:0] efl;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                                input logic [3:0] cond, input logic sf, input int hold,
                                input logic [4:0] eres, input logic eexe, input logic eill,
                                input logic [3:0] efl);
        vec_t t;
        t.a = a; t.b = b; t.op = op; t.cond = cond; t.sf = sf; t.hold = hold;
        t.eres = eres; t.eexe = eexe; t.eill = eill; t.efl = efl;
        return t;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic do_op(input vec_t t, input int idx);
        logic [8:0] r9;
        logic       pass;
        logic       ill;
        logic       exe;
        logic [4:0] res;
        logic [4:0] held_res;
        logic [3:0] held_fl;
        wait_ready();
        in_a = t.a; in_b = t.b; in_op = t.op; in_cond = t.cond; in_setflags = t.sf;
        in_valid = 1'b1;
        out_ready = (t.hold == 0);
        @(posedge clk);
        // model the accepted operation at transaction level
        pass = cond_ok(t.cond, mflags);
        ill  = (t.op > 3'd4);
        exe  = pass && !ill;
        r9   = alu_fn(t.a, t.b, t.op);
        res  = exe ? r9[4:0] : 5'd0;
        if (exe && t.sf) mflags = (t.op <= 3'd1) ? r9[8:5] : {r9[8:7], mflags[1:0]};
        expq.push_back('{res: res, exe: exe, ill: ill, fl: mflags});
        chk("model_res", 32'(res), 32'(t.eres));
        chk("model_exe", 32'(exe), 32'(t.eexe));
        chk("model_flags", 32'(mflags), 32'(t.efl));
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("latency_exec_not_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_done_valid", 32'(out_valid), 32'd1);
        chk("lit_result", 32'(out_result), 32'(t.eres));
        chk("lit_executed", 32'(out_executed), 32'(t.eexe));
        chk("lit_illegal", 32'(out_illegal), 32'(t.eill));
        chk("lit_flags", 32'(flags), 32'(t.efl));
        $display("[TB] op%0d a=%0d b=%0d op=%0d cond=%0h sf=%0d -> res=%0d exe=%0d ill=%0d flags=%b",
                 idx, t.a, t.b, t.op, t.cond, t.sf, out_result, out_executed, out_illegal, flags);
        if (t.hold > 0) begin
            held_res = out_result;
            held_fl  = flags;
            for (int i = 0; i < t.hold; i++) begin
                in_valid = 1'b1;
                in_a = 5'd9; in_op = 3'd0; in_cond = 4'hE;
                @(negedge clk);
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_result_stable", 32'(out_result), 32'(held_res));
                chk("bp_flags_stable", 32'(flags), 32'(held_fl));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("handshake_valid_low", 32'(out_valid), 32'd0);
        chk("handshake_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[15];

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_cond = '0; in_setflags = 1'b0;
        out_ready = 1'b1;
        mflags = RST_FLAGS;

        vecs[0]  = mk(5'd3,  5'd4,  3'd0, 4'hE, 1'b1, 0, 5'd7,  1'b1, 1'b0, 4'b0000);
        vecs[1]  = mk(5'd5,  5'd5,  3'd1, 4'hE, 1'b1, 0, 5'd0,  1'b1, 1'b0, 4'b0110);
        vecs[2]  = mk(5'd1,  5'd1,  3'd0, 4'h0, 1'b0, 0, 5'd2,  1'b1, 1'b0, 4'b0110);
        vecs[3]  = mk(5'd1,  5'd1,  3'd0, 4'h1, 1'b1, 0, 5'd0,  1'b0, 1'b0, 4'b0110);
        vecs[4]  = mk(5'd15, 5'd1,  3'd0, 4'hE, 1'b1, 0, 5'd16, 1'b1, 1'b0, 4'b1001);
        vecs[5]  = mk(5'd3,  5'd3,  3'd4, 4'hE, 1'b1, 3, 5'd0,  1'b1, 1'b0, 4'b0101);
        vecs[6]  = mk(5'd9,  5'd2,  3'd6, 4'hE, 1'b1, 0, 5'd0,  1'b0, 1'b1, 4'b0101);
        vecs[7]  = mk(5'd2,  5'd2,  3'd0, 4'hF, 1'b1, 0, 5'd0,  1'b0, 1'b0, 4'b0101);
        vecs[8]  = mk(5'd2,  5'd2,  3'd0, 4'hB, 1'b1, 0, 5'd4,  1'b1, 1'b0, 4'b0000);
        vecs[9]  = mk(5'd16, 5'd1,  3'd3, 4'h4, 1'b1, 0, 5'd0,  1'b0, 1'b0, 4'b0000);
        vecs[10] = mk(5'd16, 5'd1,  3'd3, 4'h5, 1'b1, 0, 5'd17, 1'b1, 1'b0, 4'b1000);
        vecs[11] = mk(5'd3,  5'd5,  3'd1, 4'h8, 1'b1, 0, 5'd0,  1'b0, 1'b0, 4'b1000);
        vecs[12] = mk(5'd3,  5'd5,  3'd1, 4'hB, 1'b1, 0, 5'd30, 1'b1, 1'b0, 4'b1000);
        vecs[13] = mk(5'd12, 5'd10, 3'd2, 4'hD, 1'b1, 0, 5'd8,  1'b1, 1'b0, 4'b0000);
        vecs[14] = mk(5'd5,  5'd5,  3'd1, 4'hE, 1'b1, 0, 5'd0,  1'b1, 1'b0, 4'b0110);

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_flags", 32'(flags), 32'(RST_FLAGS));
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_executed", 32'(out_executed), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i], i);
        end

        // Asynchronous reset while the next op sits in EXEC
        wait_ready();
        in_a = 5'd3; in_b = 5'd4; in_op = 3'd0; in_cond = 4'hE; in_setflags = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        expq.delete();
        mflags = RST_FLAGS;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_flags", 32'(flags), 32'(RST_FLAGS));
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_result", 32'(out_result), 32'd0);
        chk("midrst_executed", 32'(out_executed), 32'd0);
        $display("[TB] reset asserted mid-EXEC: flags=%b out_valid=%0d", flags, out_valid);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", 32'(out_valid), 32'd0);
        end

        do_op(mk(5'd3, 5'd4, 3'd0, 4'hE, 1'b1, 0, 5'd7, 1'b1, 1'b0, 4'b0000), 15);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
